// File: rtl/tdc_readout.sv
// TDC result FIFO with a byte-serial readout driven by an asynchronous host read strobe.
// Each 16-bit word is read high byte first; a read on an empty FIFO returns 8'hFF.
module tdc_readout #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     clr,
    input  logic                     meas_valid,
    input  logic [15:0]              meas_data,
    input  logic                     rd_req,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LO_PEND = 1'b1
    } state_t;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   head;
    logic [CW-1:0] count_nxt;
    logic [2:0]    sync;
    logic          rd_event;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic [7:0]    hold_lo;
    state_t        state;

    // sync[0] and sync[1] are the synchroniser pair; sync[2] is the edge-detect history
    assign rd_event = sync[1] & ~sync[2];
    assign head     = mem[rd_ptr];

    always_comb begin
        push_req  = meas_valid & ena & ~clr;
        do_pop    = ~clr & rd_event & (state == IDLE) & ~fifo_empty;
        // a full FIFO still accepts a word when the head leaves in the same cycle
        do_push   = push_req & (~fifo_full | do_pop);
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], rd_req};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && rst_n) begin
            mem[wr_ptr] <= meas_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_req && fifo_full && !do_pop) begin
                    overflow <= 1'b1;
                end
            end
            count      <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            fifo_full  <= (count_nxt == FULL_CNT);
        end
    end

    // only the low byte of a popped word needs holding; the high byte goes straight out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_lo    <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (clr) begin
                state <= IDLE;
            end else if (rd_event) begin
                byte_valid <= 1'b1;
                case (state)
                    IDLE: begin
                        if (!fifo_empty) begin
                            hold_lo  <= head[7:0];
                            byte_out <= head[15:8];
                            state    <= LO_PEND;
                        end else begin
                            byte_out <= '1;
                        end
                    end
                    LO_PEND: begin
                        byte_out <= hold_lo;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
